// File: rtl/shift_pipe_param_pkg.sv
// Shared types and helpers for the parametrised shift/broadcast register pipeline.
package shift_pipe_param_pkg;

  typedef enum logic {
    MODE_SHIFT = 1'b0,
    MODE_BCAST = 1'b1
  } mode_e;

  // Width needed to count 0..depth valid stages.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_pipe_param_if.sv
// Control, data and status bundle of the shift pipeline; master drives inputs, slave is the pipeline.
interface shift_pipe_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) ();
  import shift_pipe_param_pkg::*;

  localparam int CNT_W = cnt_w(DEPTH);

  logic                   en;
  mode_e                  mode;
  logic                   flush;
  logic [WIDTH-1:0]       a;
  logic                   vld_in;
  logic [WIDTH*DEPTH-1:0] taps;
  logic [WIDTH-1:0]       q;
  logic                   vld_out;
  logic [CNT_W-1:0]       fill;
  logic                   full;

  modport master (
    output en, mode, flush, a, vld_in,
    input  taps, q, vld_out, fill, full
  );

  modport slave (
    input  en, mode, flush, a, vld_in,
    output taps, q, vld_out, fill, full
  );

endinterface

// File: rtl/shift_pipe_param_stage.sv
// One pipeline stage: data + valid register, selectable between predecessor and broadcast input.
module shift_pipe_param_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             bcast_i,
  input  logic [WIDTH-1:0] pred_d_i,
  input  logic             pred_v_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] d_o,
  output logic             v_o,
  output logic             v_nxt_o
);

  logic [WIDTH-1:0] d_q, d_d, src_d;
  logic             v_q, v_d, src_v;

  // Source select and flush/enable priority; flush keeps data and drops only the valid.
  always_comb begin
    src_d = bcast_i ? a_i : pred_d_i;
    src_v = bcast_i ? vld_i : pred_v_i;
    d_d   = d_q;
    v_d   = v_q;
    if (flush_i) begin
      v_d = 1'b0;
    end else if (en_i) begin
      d_d = src_d;
      v_d = src_v;
    end else begin
      d_d = d_q;
      v_d = v_q;
    end
  end

  // Stage state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else begin
      d_q <= d_d;
      v_q <= v_d;
    end
  end

  assign d_o     = d_q;
  assign v_o     = v_q;
  assign v_nxt_o = v_d;

endmodule

// File: rtl/shift_pipe_param.sv
// Parametrised register pipeline: DEPTH stages of WIDTH bits, runtime SHIFT or BROADCAST loading,
// per-stage valids, flush, and a registered fill count of valid stages.
module shift_pipe_param
  import shift_pipe_param_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  shift_pipe_param_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0]       d_s [DEPTH];
  logic [DEPTH-1:0]       v_s;
  logic [DEPTH-1:0]       v_nxt_s;
  logic                   bcast_s;
  logic [CNT_W-1:0]       fill_d, fill_q;
  logic                   full_d, full_q;
  logic [WIDTH*DEPTH-1:0] taps_s;

  assign bcast_s = (bus.mode == MODE_BCAST);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      // The head stage has no predecessor, so both mux inputs come from a.
      shift_pipe_param_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .en_i     (bus.en),
        .flush_i  (bus.flush),
        .bcast_i  (bcast_s),
        .pred_d_i (bus.a),
        .pred_v_i (bus.vld_in),
        .a_i      (bus.a),
        .vld_i    (bus.vld_in),
        .d_o      (d_s[i]),
        .v_o      (v_s[i]),
        .v_nxt_o  (v_nxt_s[i])
      );
    end else begin : g_body
      shift_pipe_param_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .en_i     (bus.en),
        .flush_i  (bus.flush),
        .bcast_i  (bcast_s),
        .pred_d_i (d_s[i-1]),
        .pred_v_i (v_s[i-1]),
        .a_i      (bus.a),
        .vld_i    (bus.vld_in),
        .d_o      (d_s[i]),
        .v_o      (v_s[i]),
        .v_nxt_o  (v_nxt_s[i])
      );
    end
  end

  // Popcount of the next-state valids so fill lands on the same edge as the valids.
  always_comb begin
    fill_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fill_d = fill_d + CNT_W'(v_nxt_s[i]);
    end
    full_d = (fill_d == CNT_W'(DEPTH));
  end

  // Fill/full status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  // Flatten stage registers onto the tap bus, stage 0 in the low slice.
  always_comb begin
    taps_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      taps_s[i*WIDTH +: WIDTH] = d_s[i];
    end
  end

  assign bus.taps    = taps_s;
  assign bus.q       = d_s[DEPTH-1];
  assign bus.vld_out = v_s[DEPTH-1];
  assign bus.fill    = fill_q;
  assign bus.full    = full_q;

endmodule
